// File: rtl/speaker_tone_gen.sv
// Keypad-driven square-wave tone generator with octave select, release tail and PWM volume.
// Divisors are switched only on a half-period boundary, so the speaker never emits a truncated pulse.
module speaker_tone_gen #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int NUM_OCT = 3,
    parameter int DIV_W   = 20,
    parameter int VOL_W   = 3,
    parameter int REL_MS  = 200
) (
    input  logic             clk,
    input  logic             sys_rst_n,
    input  logic             key_valid,
    input  logic [3:0]       key_code,
    input  logic [VOL_W-1:0] vol,
    output logic [1:0]       scale,
    output logic [2:0]       note,
    output logic             playing,
    output logic             speaker
);

    localparam int         REL_CYC   = CLK_HZ / 1000 * REL_MS;
    localparam int         REL_W     = (REL_CYC > 1) ? $clog2(REL_CYC) : 1;
    localparam logic [REL_W-1:0] REL_LAST = REL_W'(REL_CYC - 1);
    localparam logic [1:0] SCALE_RST = (NUM_OCT > 1) ? 2'd1 : 2'd0;
    localparam logic [1:0] TOP_OCT   = 2'(NUM_OCT - 1);

    // Half-period of the highest octave, rounded to the nearest clock count.
    function automatic logic [DIV_W-1:0] top_div(input int idx);
        real f;
        case (idx)
            0:       f = 1046.50;
            1:       f = 1174.66;
            2:       f = 1318.51;
            3:       f = 1396.91;
            4:       f = 1567.98;
            5:       f = 1760.00;
            default: f = 1975.53;
        endcase
        return DIV_W'(longint'(real'(CLK_HZ) / (2.0 * f)));
    endfunction

    localparam logic [DIV_W-1:0] TOP_DIV [8] = '{
        top_div(0), top_div(1), top_div(2), top_div(3),
        top_div(4), top_div(5), top_div(6), '0
    };

    typedef enum logic [1:0] {IDLE, PLAY, RELEASE} state_t;

    state_t           state, state_next;
    logic [DIV_W-1:0] div_q, cnt_q, new_div;
    logic [REL_W-1:0] rel_cnt_q;
    logic [VOL_W-1:0] pwm_cnt_q;
    logic [2:0]       note_q;
    logic [1:0]       scale_q;
    logic             sq_q, playing_q;
    logic             note_press, oct_press, half_done;

    assign note_press = key_valid && (key_code >= 4'd1) && (key_code <= 4'd7);
    assign oct_press  = key_valid && (key_code >= 4'd10) && (key_code <= 4'd13)
                        && ((key_code - 4'd10) < 4'(NUM_OCT));
    assign new_div    = TOP_DIV[key_code[2:0] - 3'd1] << (TOP_OCT - scale_q);
    assign half_done  = (cnt_q == div_q - DIV_W'(1));

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (note_press) state_next = PLAY;
            PLAY:    if (!note_press) state_next = (REL_CYC == 0) ? IDLE : RELEASE;
            RELEASE: begin
                if (note_press)                  state_next = PLAY;
                else if (rel_cnt_q == REL_LAST)  state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= IDLE;
            playing_q <= 1'b0;
            scale_q   <= SCALE_RST;
            pwm_cnt_q <= '0;
        end else begin
            state     <= state_next;
            playing_q <= (state_next != IDLE);
            pwm_cnt_q <= pwm_cnt_q + VOL_W'(1);
            if (oct_press) scale_q <= 2'(key_code - 4'd10);
        end
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            div_q     <= '0;
            cnt_q     <= '0;
            rel_cnt_q <= '0;
            note_q    <= '0;
            sq_q      <= 1'b0;
        end else if (state_next == IDLE) begin
            cnt_q     <= '0;
            rel_cnt_q <= '0;
            note_q    <= '0;
            sq_q      <= 1'b0;
        end else if (state == IDLE) begin
            div_q     <= new_div;
            note_q    <= key_code[2:0];
            cnt_q     <= '0;
            rel_cnt_q <= '0;
            sq_q      <= 1'b0;
        end else begin
            if (half_done) begin
                cnt_q <= '0;
                sq_q  <= ~sq_q;
                // A held note (possibly changed) takes effect only at this boundary.
                if (note_press) begin
                    div_q  <= new_div;
                    note_q <= key_code[2:0];
                end
            end else begin
                cnt_q <= cnt_q + DIV_W'(1);
            end
            rel_cnt_q <= (state == RELEASE && state_next == RELEASE)
                         ? rel_cnt_q + REL_W'(1) : '0;
        end
    end

    assign scale   = scale_q;
    assign note    = note_q;
    assign playing = playing_q;
    assign speaker = sq_q && (state != IDLE) && ((vol == '1) || (pwm_cnt_q < vol));

endmodule

// File: tb/tb_speaker_tone_gen.sv
// Directed bench for speaker_tone_gen, run at a 1 MHz clock so tones and the 1 ms release stay short.
// Half-periods there: C..B = 478 426 379 358 319 284 253 clocks in the top octave.
module tb_speaker_tone_gen;

    localparam int CLK_HZ  = 1_000_000;
    localparam int NUM_OCT = 3;
    localparam int DIV_W   = 20;
    localparam int VOL_W   = 3;
    localparam int REL_MS  = 1;

    logic             clk = 1'b0;
    logic             sys_rst_n;
    logic             key_valid;
    logic [3:0]       key_code;
    logic [VOL_W-1:0] vol;
    logic [1:0]       scale;
    logic [2:0]       note;
    logic             playing;
    logic             speaker;

    int checks = 0;
    int errors = 0;

    speaker_tone_gen #(
        .CLK_HZ(CLK_HZ), .NUM_OCT(NUM_OCT), .DIV_W(DIV_W), .VOL_W(VOL_W), .REL_MS(REL_MS)
    ) dut (
        .clk(clk), .sys_rst_n(sys_rst_n), .key_valid(key_valid), .key_code(key_code),
        .vol(vol), .scale(scale), .note(note), .playing(playing), .speaker(speaker)
    );

    always #5 clk = ~clk;

    // Negedges until speaker changes; -1 if it stays put past the limit.
    task automatic wait_change(input int limit, output int cyc);
        logic start;
        start = speaker;
        cyc   = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (speaker == start && cyc <= limit);
        if (speaker == start) cyc = -1;
    endtask

    task automatic wait_idle(input int limit, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (playing && cyc <= limit);
        if (playing) cyc = -1;
    endtask

    task automatic count_high(input int n, output int hi);
        hi = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (speaker) hi++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        sys_rst_n = 1'b0;
        key_valid = 1'b0;
        key_code  = 4'd0;
        vol       = 3'd7;
        repeat (3) @(negedge clk);
        sys_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        sys_rst_n = 1'b0;
        key_valid = 1'b1;
        key_code  = 4'd6;
        vol       = 3'd7;
        repeat (4) @(negedge clk);
        checks++; if (scale !== 2'd1) begin errors++; $display("FAIL reset_scale got %0d want 1", scale); end
        checks++; if (note !== 3'd0) begin errors++; $display("FAIL reset_note got %0d want 0", note); end
        checks++; if (playing !== 1'b0) begin errors++; $display("FAIL reset_playing got %b want 0", playing); end
        checks++; if (speaker !== 1'b0) begin errors++; $display("FAIL reset_speaker got %b want 0", speaker); end
    endtask

    // Key 6 held through reset: octave 1 A -> 284<<1 = 568 clocks per half-period.
    task automatic test_first_tone();
        int cyc;
        sys_rst_n = 1'b1;
        @(negedge clk);
        checks++; if (playing !== 1'b1) begin errors++; $display("FAIL first_playing got %b want 1", playing); end
        checks++; if (note !== 3'd6) begin errors++; $display("FAIL first_note got %0d want 6", note); end
        checks++; if (speaker !== 1'b0) begin errors++; $display("FAIL first_start_level got %b want 0", speaker); end
        wait_change(2000, cyc);
        checks++; if (cyc !== 568) begin errors++; $display("FAIL first_half got %0d want 568", cyc); end
        checks++; if (speaker !== 1'b1) begin errors++; $display("FAIL first_level got %b want 1", speaker); end
        wait_change(2000, cyc);
        checks++; if (cyc !== 568) begin errors++; $display("FAIL second_half got %0d want 568", cyc); end
    endtask

    task automatic test_octave();
        int cyc;
        do_reset();
        key_valid = 1'b1;
        key_code  = 4'd12;
        @(negedge clk);
        checks++; if (scale !== 2'd2) begin errors++; $display("FAIL oct_c got %0d want 2", scale); end
        checks++; if (playing !== 1'b0) begin errors++; $display("FAIL oct_not_note got %b want 0", playing); end
        key_code = 4'd13;
        @(negedge clk);
        checks++; if (scale !== 2'd2) begin errors++; $display("FAIL oct_d_ignored got %0d want 2", scale); end
        key_code = 4'd15;
        @(negedge clk);
        checks++; if (playing !== 1'b0) begin errors++; $display("FAIL code15_ignored got %b want 0", playing); end
        key_code = 4'd1;
        @(negedge clk);
        checks++; if (note !== 3'd1) begin errors++; $display("FAIL oct_note got %0d want 1", note); end
        wait_change(2000, cyc);
        checks++; if (cyc !== 478) begin errors++; $display("FAIL oct2_half got %0d want 478", cyc); end
    endtask

    // Note 1 (956) -> note 5 (319<<1 = 638) mid half-period.
    task automatic test_note_change();
        int cyc;
        do_reset();
        key_valid = 1'b1;
        key_code  = 4'd1;
        @(negedge clk);
        wait_change(3000, cyc);
        checks++; if (cyc !== 956) begin errors++; $display("FAIL note1_half got %0d want 956", cyc); end
        repeat (100) @(negedge clk);
        key_code = 4'd5;
        @(negedge clk);
        checks++; if (note !== 3'd1) begin errors++; $display("FAIL note_held_old got %0d want 1", note); end
        wait_change(3000, cyc);
        checks++; if (cyc !== 855) begin errors++; $display("FAIL old_half_rest got %0d want 855", cyc); end
        checks++; if (note !== 3'd5) begin errors++; $display("FAIL note_switched got %0d want 5", note); end
        wait_change(3000, cyc);
        checks++; if (cyc !== 638) begin errors++; $display("FAIL new_half got %0d want 638", cyc); end
    endtask

    // Continues from note 5 just after a toggle; release tail is 1000 clocks.
    task automatic test_release();
        int cyc;
        key_valid = 1'b0;
        key_code  = 4'd2;
        wait_change(2000, cyc);
        checks++; if (cyc !== 638) begin errors++; $display("FAIL release_tone got %0d want 638", cyc); end
        repeat (200) @(negedge clk);
        checks++; if (playing !== 1'b1) begin errors++; $display("FAIL release_playing got %b want 1", playing); end
        checks++; if (note !== 3'd5) begin errors++; $display("FAIL release_note got %0d want 5", note); end
        key_valid = 1'b1;
        key_code  = 4'd5;
        repeat (10) @(negedge clk);
        key_valid = 1'b0;
        wait_idle(3000, cyc);
        checks++; if (cyc !== 1001) begin errors++; $display("FAIL release_len got %0d want 1001", cyc); end
        checks++; if (note !== 3'd0) begin errors++; $display("FAIL idle_note got %0d want 0", note); end
        checks++; if (speaker !== 1'b0) begin errors++; $display("FAIL idle_speaker got %b want 0", speaker); end
    endtask

    // Key 6 octave 1: 1136-clock period, 568 square-high clocks, multiple of 8.
    task automatic test_volume();
        int hi;
        do_reset();
        vol       = 3'd0;
        key_valid = 1'b1;
        key_code  = 4'd6;
        @(negedge clk);
        count_high(1136, hi);
        checks++; if (hi !== 0) begin errors++; $display("FAIL vol0_high got %0d want 0", hi); end
        checks++; if (playing !== 1'b1) begin errors++; $display("FAIL vol0_playing got %b want 1", playing); end
        vol = 3'd3;
        count_high(1136, hi);
        checks++; if (hi !== 213) begin errors++; $display("FAIL vol3_high got %0d want 213", hi); end
        vol = 3'd7;
        count_high(1136, hi);
        checks++; if (hi !== 568) begin errors++; $display("FAIL vol7_high got %0d want 568", hi); end
    endtask

    task automatic test_reset_mid_tone();
        int cyc;
        do_reset();
        key_valid = 1'b1;
        key_code  = 4'd12;
        @(negedge clk);
        key_code = 4'd6;
        @(negedge clk);
        wait_change(1000, cyc);
        checks++; if (cyc !== 284) begin errors++; $display("FAIL mid_half got %0d want 284", cyc); end
        #2 sys_rst_n = 1'b0;
        #1;
        checks++; if (speaker !== 1'b0) begin errors++; $display("FAIL mid_rst_speaker got %b want 0", speaker); end
        checks++; if (playing !== 1'b0) begin errors++; $display("FAIL mid_rst_playing got %b want 0", playing); end
        checks++; if (note !== 3'd0) begin errors++; $display("FAIL mid_rst_note got %0d want 0", note); end
        checks++; if (scale !== 2'd1) begin errors++; $display("FAIL mid_rst_scale got %0d want 1", scale); end
        @(negedge clk);
        sys_rst_n = 1'b1;
        @(negedge clk);
        checks++; if (playing !== 1'b1) begin errors++; $display("FAIL restart_playing got %b want 1", playing); end
        wait_change(2000, cyc);
        checks++; if (cyc !== 568) begin errors++; $display("FAIL restart_half got %0d want 568", cyc); end
    endtask

    initial begin
        sys_rst_n = 1'b0;
        key_valid = 1'b0;
        key_code  = 4'd0;
        vol       = 3'd7;
        test_reset();
        test_first_tone();
        test_octave();
        test_note_change();
        test_release();
        test_volume();
        test_reset_mid_tone();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired after %0d checks", checks);
        $fatal(1, "watchdog");
    end

endmodule
